// File: rtl/psram_arb_pkg.sv
// Shared types and helpers for the PSRAM request arbiter.
package psram_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_STROBE,
      ARB_ACCEPT,
      ARB_DONE
   } ArbState;

   localparam int ACCEPT_TIMEOUT_DEFAULT = 8;
   localparam int ADDR_W                 = 24;
   localparam int DATA_W                 = 8;

   // (base + offset) mod n, valid for base < n and offset <= n.
   function automatic int rr_index(input int base, input int offset, input int n);
      int sum;
      sum = base + offset;
      return (sum >= n) ? sum - n : sum;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping mod NREQ.
module rr_pick
   import psram_arb_pkg::*;
#(
   parameter  int NREQ  = 3,
   localparam int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [PTR_W-1:0] winner_o,
   output logic             valid_o
);

   logic [PTR_W-1:0] cand [NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         cand[i] = PTR_W'(rr_index(int'(ptr_i), i, NREQ));
      end
   end

   // Scan from the farthest candidate back toward ptr_i so the nearest one wins last.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      winner_o = '0;
      valid_o  = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_i[cand[i]]) begin
            winner_o = cand[i];
            valid_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller between NREQ requesters.
// One command in flight; single-cycle strobe, re-strobed if the controller never goes busy.
module psram_arbiter
   import psram_arb_pkg::*;
#(
   parameter  int NREQ           = 3,
   parameter  int ACCEPT_TIMEOUT = ACCEPT_TIMEOUT_DEFAULT,
   localparam int PTR_W          = $clog2(NREQ)
) (
   input  logic                     i_clkRAM,
   input  logic                     reset,
   input  logic [NREQ-1:0]          i_req,
   input  logic [NREQ-1:0]          i_write,
   input  logic [NREQ*ADDR_W-1:0]   i_addr,
   input  logic [NREQ-1:0]          i_bank,
   input  logic [NREQ*DATA_W-1:0]   i_wdata,
   output logic [NREQ-1:0]          o_ack,
   output logic [NREQ-1:0]          o_done,
   output logic [DATA_W-1:0]        o_rdata,
   output logic                     o_mem_cs,
   output logic                     o_mem_write,
   output logic                     o_mem_bank,
   output logic [ADDR_W-1:0]        o_mem_address,
   output logic [DATA_W-1:0]        o_mem_wdata,
   input  logic                     i_mem_busy,
   input  logic                     i_mem_dataReady,
   input  logic [DATA_W-1:0]        i_mem_dataRead,
   output logic [PTR_W-1:0]         o_owner
);

   localparam int TMO_W = $clog2(ACCEPT_TIMEOUT + 1);

   ArbState           state_q;
   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  owner_q;
   logic [NREQ-1:0]   ack_q;
   logic [NREQ-1:0]   done_q;
   logic [DATA_W-1:0] rdata_q;
   logic              cs_q;
   logic              write_q;
   logic              bank_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [TMO_W-1:0]  tmo_q;

   logic [ADDR_W-1:0] addr_a  [NREQ];
   logic [DATA_W-1:0] wdata_a [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_a[g]  = i_addr[g*ADDR_W +: ADDR_W];
      assign wdata_a[g] = i_wdata[g*DATA_W +: DATA_W];
   end

   logic [PTR_W-1:0] pick_winner;
   logic             pick_valid;

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .req_i    (i_req),
      .ptr_i    (ptr_q),
      .winner_o (pick_winner),
      .valid_o  (pick_valid)
   );

   logic [PTR_W-1:0] ptr_d;
   assign ptr_d = PTR_W'(rr_index(int'(pick_winner), 1, NREQ));

   always_ff @(posedge i_clkRAM) begin
      if (!reset) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         ack_q   <= '0;
         done_q  <= '0;
         rdata_q <= '0;
         cs_q    <= 1'b1;
         write_q <= 1'b0;
         bank_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         tmo_q   <= '0;
      end else begin
         // NOTE: pulse outputs fall back to zero every cycle; only the branch that fires raises a bit.
         ack_q  <= '0;
         done_q <= '0;
         case (state_q)
            ARB_IDLE: begin
               if (pick_valid && !i_mem_busy) begin
                  write_q            <= i_write[pick_winner];
                  bank_q             <= i_bank[pick_winner];
                  addr_q             <= addr_a[pick_winner];
                  wdata_q            <= wdata_a[pick_winner];
                  owner_q            <= pick_winner;
                  ack_q[pick_winner] <= 1'b1;
                  ptr_q              <= ptr_d;
                  cs_q               <= 1'b0;
                  state_q            <= ARB_STROBE;
               end
            end
            ARB_STROBE: begin
               cs_q    <= 1'b1;
               tmo_q   <= '0;
               state_q <= ARB_ACCEPT;
            end
            ARB_ACCEPT: begin
               // Controller never acknowledged: repeat the strobe with the same latched command.
               if (i_mem_busy) begin
                  state_q <= ARB_DONE;
               end else if (tmo_q == TMO_W'(ACCEPT_TIMEOUT - 1)) begin
                  cs_q    <= 1'b0;
                  state_q <= ARB_STROBE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            ARB_DONE: begin
               if (write_q) begin
                  if (!i_mem_busy) begin
                     done_q[owner_q] <= 1'b1;
                     state_q         <= ARB_IDLE;
                  end
               end else if (i_mem_dataReady) begin
                  rdata_q         <= i_mem_dataRead;
                  done_q[owner_q] <= 1'b1;
                  state_q         <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign o_ack         = ack_q;
   assign o_done        = done_q;
   assign o_rdata       = rdata_q;
   assign o_mem_cs      = cs_q;
   assign o_mem_write   = write_q;
   assign o_mem_bank    = bank_q;
   assign o_mem_address = addr_q;
   assign o_mem_wdata   = wdata_q;
   assign o_owner       = owner_q;

endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

Round-robin arbiter that shares the single 8-bit PSRAM memory controller between NREQ requesters (CPU, video fetch, cartridge/ROM loader). It latches one request at a time, drives the controller's active-low strobe for exactly one cycle, tracks completion via the controller's busy/data-ready outputs, and returns read data and a done pulse to the owning requester. Sits between the system bus logic and the PSRAM controller, in the i_clkRAM domain.

## Interface
- NREQ, 3: number of requesters, 2..8
- ACCEPT_TIMEOUT, 8: cycles to wait for controller busy after strobe before re-strobing
- reset: reset, synchronous, active-low; clock i_clkRAM
- i_clkRAM  in  1  PSRAM clock (100 MHz)
- reset  in  1  synchronous active-low reset
- i_req  in  NREQ  per-requester request level; held until o_ack
- i_write  in  NREQ  per-requester 1=write, 0=read
- i_addr  in  NREQ*24  flattened addresses, requester k at [24k+23:24k]
- i_bank  in  NREQ  per-requester bank select
- i_wdata  in  NREQ*8  flattened write data
- o_ack  out  NREQ  one-cycle pulse: request latched; requester may change inputs next cycle
- o_done  out  NREQ  one-cycle pulse: transaction finished (read data valid for reads)
- o_rdata  out  8  read data, valid while o_done bit of a read owner is high, held until next read completes
- o_mem_cs  out  1  controller strobe, 0=select
- o_mem_write, o_mem_bank  out  1 each  latched command fields
- o_mem_address  out  24  latched address
- o_mem_wdata  out  8  latched write data
- i_mem_busy, i_mem_dataReady  in  1 each  controller status
- i_mem_dataRead  in  8  controller read data
- o_owner  out  $clog2(NREQ)  index of current/last owner (debug)

## Operation
- States: ARB_IDLE, ARB_STROBE, ARB_ACCEPT, ARB_DONE.
- ARB_IDLE: if any i_req and i_mem_busy==0: pick winner = first set bit scanning from pointer ptr upward mod NREQ; latch write/addr/bank/wdata, owner; pulse o_ack[winner]; ptr<=winner+1 mod NREQ; go ARB_STROBE. If i_mem_busy==1 (controller init or finishing), wait.
- ARB_STROBE: o_mem_cs=0 for this single cycle; clear timeout counter; go ARB_ACCEPT.
- ARB_ACCEPT: if i_mem_busy==1 go ARB_DONE; else increment counter; at ACCEPT_TIMEOUT return to ARB_STROBE (re-strobe, same latched command, no new o_ack).
- ARB_DONE: read: on i_mem_dataReady==1 capture i_mem_dataRead into o_rdata, pulse o_done[owner], go ARB_IDLE. Write: on i_mem_busy==0 pulse o_done[owner], go ARB_IDLE.
- o_mem_cs is 1 in every state except ARB_STROBE; command outputs stable from ARB_STROBE through ARB_DONE.
- Requests arriving while not in ARB_IDLE are only considered in ARB_IDLE; i_req deasserted before o_ack is simply dropped.

## Timing
- Reset values: o_mem_cs=1, o_ack=0, o_done=0, o_rdata=0, o_mem_write=0, o_mem_bank=0, o_mem_address=0, o_mem_wdata=0, o_owner=0, ptr=0, state ARB_IDLE.
- Cycle N: request sampled in ARB_IDLE with busy=0 -> N+1: o_ack high, o_mem_cs=0 -> N+2: o_mem_cs=1.
- o_done asserted the cycle after the completion condition is sampled; earliest next o_ack for another requester is the cycle after o_done.
- Simultaneous requests from all NREQ: grant order ptr, ptr+1, ... fair; no requester waits more than NREQ-1 transactions.
- Reset mid-transaction: everything to reset values, no o_done emitted; requesters without o_ack keep i_req and are retried.
- i_mem_busy held high after reset (controller init): arbiter stays in ARB_IDLE, no strobe.

## Structure
- Shared package psram_arb_pkg: ArbState enum, ACCEPT_TIMEOUT default.
- Sub-module rr_pick: combinational round-robin winner from i_req and ptr, outputs winner index and any-valid.

## Test plan
- Single read, req 1, addr 24'h00D020, controller returns 8'h5A -> one o_ack[1], exactly one cycle o_mem_cs=0, o_done[1] with o_rdata=8'h5A.
- Single write, req 0, addr 24'h000400, wdata 8'h41, bank 1 -> o_mem_write=1, o_mem_bank=1, o_done[0] after busy falls, no o_rdata change.
- All three requesting continuously from reset -> grant sequence 0,1,2,0,1,2; each o_ack exactly once per transaction.
- Controller busy held 1 for 20000 cycles after reset with req 2 high -> no strobe until busy=0, then normal grant to 2.
- Controller ignores first strobe (busy stays 0) -> re-strobe after ACCEPT_TIMEOUT cycles, single o_ack, single o_done.
- Reset asserted in ARB_DONE -> all outputs at reset values next cycle, no o_done; held request re-granted after reset release.
